// File: rtl/fpu_test_harness.sv
// Stimulus/response harness for single-issue FPU units: assembles operands
// from a narrow input stream, issues them, and folds results into a MISR.
module fpu_test_harness #(
    parameter int              DATA_W  = 32,
    parameter int              IN_W    = 16,
    parameter int              NUM_OPS = 2,
    parameter int              MAX_OUT = 8,
    parameter int              TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] POLY  = 32'h04C11DB7,
    parameter int              CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [IN_W-1:0]           in_data,
    output logic                      in_ready,
    output logic                      dut_valid,
    output logic [NUM_OPS*DATA_W-1:0] dut_ops,
    input  logic                      dut_ready,
    input  logic                      res_valid,
    input  logic [DATA_W-1:0]         res_data,
    output logic [DATA_W-1:0]         signature,
    output logic [CNT_W-1:0]          issue_cnt,
    output logic [CNT_W-1:0]          res_cnt,
    output logic                      err_spurious,
    output logic                      err_timeout,
    output logic [15:0]               led
);

    localparam int CHUNKS = DATA_W / IN_W;
    localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int OP_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic {COLLECT, ISSUE} state_e;

    state_e                    state_q, state_d;
    logic [NUM_OPS*DATA_W-1:0] ops_q, ops_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [OP_W-1:0]           op_q, op_d;
    logic [OUT_W-1:0]          out_q, out_d;
    logic [DATA_W-1:0]         sig_q, sig_d;
    logic [CNT_W-1:0]          icnt_q, icnt_d;
    logic [CNT_W-1:0]          rcnt_q, rcnt_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic                      esp_q, esp_d;
    logic                      eto_q, eto_d;
    logic                      rdy_q, rdy_d;

    logic              accept, fire, res_ok;
    logic [DATA_W-1:0] cur;

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        ch_d    = ch_q;
        op_d    = op_q;
        out_d   = out_q;
        sig_d   = sig_q;
        icnt_d  = icnt_q;
        rcnt_d  = rcnt_q;
        wd_d    = wd_q;
        esp_d   = esp_q;
        eto_d   = eto_q;
        cur     = ops_q[op_q*DATA_W +: DATA_W];

        accept = in_valid && rdy_q;
        fire   = (state_q == ISSUE) && dut_ready;
        // A result may pair with an issue happening in the same cycle.
        res_ok = res_valid && ((out_q != '0) || fire);

        if (accept) begin
            ops_d[op_q*DATA_W +: DATA_W] = (cur << IN_W) | DATA_W'(in_data);
            if (ch_q == CH_W'(CHUNKS - 1)) begin
                ch_d = '0;
                if (op_q == OP_W'(NUM_OPS - 1)) begin
                    op_d    = '0;
                    state_d = ISSUE;
                end else begin
                    op_d = op_q + OP_W'(1);
                end
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end

        if (fire) begin
            state_d = COLLECT;
            icnt_d  = icnt_q + CNT_W'(1);
        end

        if (fire && !res_ok)
            out_d = out_q + OUT_W'(1);
        else if (!fire && res_ok)
            out_d = out_q - OUT_W'(1);

        if (res_ok) begin
            sig_d = {sig_q[DATA_W-2:0], 1'b0}
                  ^ (sig_q[DATA_W-1] ? POLY : '0)
                  ^ res_data;
            rcnt_d = rcnt_q + CNT_W'(1);
        end

        if (res_valid && !res_ok)
            esp_d = 1'b1;

        if (res_valid || (out_q == '0))
            wd_d = '0;
        else if (wd_q != WD_W'(TIMEOUT))
            wd_d = wd_q + WD_W'(1);
        if (wd_d == WD_W'(TIMEOUT))
            eto_d = 1'b1;

        // Clear only touches the observation side, never the datapath.
        if (clr) begin
            sig_d  = '0;
            icnt_d = '0;
            rcnt_d = '0;
            wd_d   = '0;
            esp_d  = 1'b0;
            eto_d  = 1'b0;
        end

        rdy_d = (state_d == COLLECT) && (out_d < OUT_W'(MAX_OUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            ops_q   <= '0;
            ch_q    <= '0;
            op_q    <= '0;
            out_q   <= '0;
            sig_q   <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            wd_q    <= '0;
            esp_q   <= 1'b0;
            eto_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            ch_q    <= ch_d;
            op_q    <= op_d;
            out_q   <= out_d;
            sig_q   <= sig_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            wd_q    <= wd_d;
            esp_q   <= esp_d;
            eto_q   <= eto_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready     = rdy_q;
    assign dut_valid    = (state_q == ISSUE);
    assign dut_ops      = ops_q;
    assign signature    = sig_q;
    assign issue_cnt    = icnt_q;
    assign res_cnt      = rcnt_q;
    assign err_spurious = esp_q;
    assign err_timeout  = eto_q;
    assign led          = {eto_q, esp_q, ^sig_q, sig_q[12:0]};

endmodule

// File: tb/tb_fpu_test_harness.sv
// Directed bench for fpu_test_harness (MAX_OUT=2, TIMEOUT=16).
module tb_fpu_test_harness;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        dut_valid;
    logic [63:0] dut_ops;
    logic        dut_ready = 1'b1;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic [31:0] signature;
    logic [15:0] issue_cnt;
    logic [15:0] res_cnt;
    logic        err_spurious;
    logic        err_timeout;
    logic [15:0] led;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpu_test_harness #(
        .MAX_OUT(2),
        .TIMEOUT(16)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dut_valid   (dut_valid),
        .dut_ops     (dut_ops),
        .dut_ready   (dut_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .signature   (signature),
        .issue_cnt   (issue_cnt),
        .res_cnt     (res_cnt),
        .err_spurious(err_spurious),
        .err_timeout (err_timeout),
        .led         (led)
    );

    task automatic do_reset();
        in_valid  = 1'b0;
        res_valid = 1'b0;
        clr       = 1'b0;
        dut_ready = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_chunk(input logic [15:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 40) begin
            tests++;
            fails++;
            $display("FAIL chunk_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a0, input logic [31:0] a1);
        send_chunk(a0[31:16]);
        send_chunk(a0[15:0]);
        send_chunk(a1[31:16]);
        send_chunk(a1[15:0]);
    endtask

    task automatic send_result(input logic [31:0] d);
        res_valid = 1'b1;
        res_data  = d;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, dut_valid, err_spurious, err_timeout} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000",
                     {in_ready, dut_valid, err_spurious, err_timeout});
        end
        tests++;
        if ({dut_ops, signature, issue_cnt, res_cnt, led} !== '0) begin
            fails++;
            $display("FAIL reset_regs: sig=%h ops=%h required 0",
                     signature, dut_ops);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_release: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_first_cycle: got %b required 1", in_ready);
        end
    endtask

    task automatic test_issue();
        logic [15:0] ch [4];
        ch[0] = 16'h4000; ch[1] = 16'h0000;
        ch[2] = 16'h3F80; ch[3] = 16'h0000;
        dut_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = ch[i];
            tests++;
            if (dut_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL collect_%0d: valid=%b ready=%b required 0/1",
                         i, dut_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (dut_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL issue_state: valid=%b ready=%b required 1/0",
                     dut_valid, in_ready);
        end
        tests++;
        if (dut_ops !== {32'h3F800000, 32'h40000000}) begin
            fails++;
            $display("FAIL issue_ops: got %h required 3f80000040000000",
                     dut_ops);
        end
        @(posedge clk); #1;
        tests++;
        if (dut_valid !== 1'b0 || issue_cnt !== 16'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_done: valid=%b cnt=%0d ready=%b required 0/1/1",
                     dut_valid, issue_cnt, in_ready);
        end
    endtask

    task automatic test_results();
        logic [31:0] e;
        send_op(32'h0, 32'h0);
        @(posedge clk); #1;
        tests++;
        if (issue_cnt !== 16'd2) begin
            fails++;
            $display("FAIL second_issue: got %0d required 2", issue_cnt);
        end
        send_result(32'h3FB504F3);
        tests++;
        if (signature !== 32'h3FB504F3) begin
            fails++;
            $display("FAIL sig_first: got %h required 3fb504f3", signature);
        end
        send_result(32'h40000000);
        tests++;
        if (signature !== 32'h3F6A09E6 || res_cnt !== 16'd2) begin
            fails++;
            $display("FAIL sig_second: got %h cnt=%0d required 3f6a09e6/2",
                     signature, res_cnt);
        end
        e = 32'h3F6A09E6;
        tests++;
        if (led[13:0] !== {^e, e[12:0]}) begin
            fails++;
            $display("FAIL led_sig: got %h required %h", led[13:0],
                     {^e, e[12:0]});
        end
    endtask

    task automatic test_stall();
        do_reset();
        dut_ready = 1'b0;
        send_op(32'h11112222, 32'h33334444);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (dut_valid !== 1'b1 || in_ready !== 1'b0 ||
                dut_ops !== {32'h33334444, 32'h11112222}) begin
                fails++;
                $display("FAIL stall_%0d: valid=%b ready=%b ops=%h", i,
                         dut_valid, in_ready, dut_ops);
            end
        end
        in_valid  = 1'b0;
        dut_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (dut_valid !== 1'b0 || issue_cnt !== 16'd1) begin
            fails++;
            $display("FAIL stall_single: valid=%b cnt=%0d required 0/1",
                     dut_valid, issue_cnt);
        end
        dut_ready = 1'b0;
        send_op(32'h55556666, 32'h77778888);
        tests++;
        if (dut_ops !== {32'h77778888, 32'h55556666}) begin
            fails++;
            $display("FAIL stall_next_ops: got %h required 7777888855556666",
                     dut_ops);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_op(32'hA0A0A0A0, 32'hA1A1A1A1);
        @(posedge clk); #1;
        send_op(32'hB0B0B0B0, 32'hB1B1B1B1);
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b0 || issue_cnt !== 16'd2) begin
            fails++;
            $display("FAIL full_block: ready=%b cnt=%0d required 0/2",
                     in_ready, issue_cnt);
        end
        in_valid = 1'b1;
        in_data  = 16'h7777;
        repeat (3) begin
            @(posedge clk); #1;
        end
        tests++;
        if (in_ready !== 1'b0 || dut_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: ready=%b valid=%b required 0/0",
                     in_ready, dut_valid);
        end
        in_valid = 1'b0;
        send_result(32'h00000001);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reopen: got %b required 1", in_ready);
        end
        dut_ready = 1'b0;
        send_op(32'hC0C0C0C0, 32'hC1C1C1C1);
        dut_ready = 1'b1;
        send_result(32'h00000002);
        tests++;
        if (issue_cnt !== 16'd3 || res_cnt !== 16'd2 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL simul: icnt=%0d rcnt=%0d ready=%b required 3/2/1",
                     issue_cnt, res_cnt, in_ready);
        end
        tests++;
        if (signature !== 32'h00000000) begin
            fails++;
            $display("FAIL simul_sig: got %h required 00000000", signature);
        end
        send_op(32'hD0D0D0D0, 32'hD1D1D1D1);
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b0 || issue_cnt !== 16'd4) begin
            fails++;
            $display("FAIL out_const: ready=%b cnt=%0d required 0/4",
                     in_ready, issue_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_result(32'h12345678);
        tests++;
        if (err_spurious !== 1'b1 || signature !== '0 || res_cnt !== '0) begin
            fails++;
            $display("FAIL spurious: err=%b sig=%h cnt=%0d required 1/0/0",
                     err_spurious, signature, res_cnt);
        end
        tests++;
        if (led[14] !== 1'b1) begin
            fails++;
            $display("FAIL led_spurious: got %b required 1", led[14]);
        end
        send_op(32'h1, 32'h2);
        @(posedge clk); #1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        tests++;
        if (err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: got %b required 0", err_timeout);
        end
        @(posedge clk); #1;
        tests++;
        if (err_timeout !== 1'b1 || led[15] !== 1'b1) begin
            fails++;
            $display("FAIL timeout_set: got %b led=%b required 1/1",
                     err_timeout, led[15]);
        end
        send_result(32'hA5A5A5A5);
        tests++;
        if (signature !== 32'hA5A5A5A5 || res_cnt !== 16'd1) begin
            fails++;
            $display("FAIL pre_clr: sig=%h cnt=%0d required a5a5a5a5/1",
                     signature, res_cnt);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        tests++;
        if ({err_spurious, err_timeout} !== 2'b00 || signature !== '0 ||
            issue_cnt !== '0 || res_cnt !== '0 || led !== '0) begin
            fails++;
            $display("FAIL clr: errs=%b sig=%h ic=%0d rc=%0d led=%h",
                     {err_spurious, err_timeout}, signature, issue_cnt,
                     res_cnt, led);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_chunk(16'h4000);
        send_chunk(16'h0000);
        send_chunk(16'h3F80);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, dut_valid} !== 2'b00 || dut_ops !== '0 || led !== '0) begin
            fails++;
            $display("FAIL mid_reset: ready=%b valid=%b ops=%h required 0",
                     in_ready, dut_valid, dut_ops);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_chunk(16'h0000);
        tests++;
        if (dut_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_issue: got %b required 0", dut_valid);
        end
        send_chunk(16'h1234);
        send_chunk(16'h5678);
        tests++;
        if (dut_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_three: got %b required 0", dut_valid);
        end
        send_chunk(16'h9ABC);
        tests++;
        if (dut_valid !== 1'b1 || dut_ops !== {32'h56789ABC, 32'h00001234}) begin
            fails++;
            $display("FAIL mid_fresh: valid=%b ops=%h required 1/56789abc00001234",
                     dut_valid, dut_ops);
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_results();
        test_stall();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_test_harness.md
Name: fpu_test_harness

Overview:
- Parametrised board-level stimulus/response harness for single-cycle-issue FPU units (fsqrt, fadd, fmul, ...).
- Builds NUM_OPS operands of DATA_W bits from a narrow IN_W-bit input stream and issues them to an external DUT with a valid/ready handshake.
- Tracks outstanding operations, folds every returned result into a MISR signature, and flags spurious-result and timeout errors.
- Sits between FPGA switch/pin logic and the FPU under test; the signature and error flags drive LEDs, so no DUT logic is optimised away.

Parameters:
- DATA_W, 32, operand/result width; must be a multiple of IN_W.
- IN_W, 16, input chunk width.
- NUM_OPS, 2, operands per operation (1..3).
- MAX_OUT, 8, maximum in-flight operations (1..255).
- TIMEOUT, 1024, cycles without a result while ops are outstanding before the timeout error.
- POLY, 32'h04C11DB7, MISR feedback polynomial (DATA_W bits).
- CNT_W, 16, width of the issue and result counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of signature, counters and error flags
- in_valid  in  1  in_data holds a valid chunk
- in_data  in  IN_W  input chunk
- in_ready  out  1  harness accepts a chunk this cycle
- dut_valid  out  1  operands valid to DUT
- dut_ops  out  NUM_OPS*DATA_W  operand k at [k*DATA_W +: DATA_W]
- dut_ready  in  1  DUT accepts operands
- res_valid  in  1  DUT result valid
- res_data  in  DATA_W  DUT result
- signature  out  DATA_W  MISR state
- issue_cnt  out  CNT_W  operations issued (wraps)
- res_cnt  out  CNT_W  results accepted (wraps)
- err_spurious  out  1  sticky: result arrived with no operation outstanding
- err_timeout  out  1  sticky: watchdog expired
- led  out  16  {err_timeout, err_spurious, ^signature, signature[12:0]}

Behaviour:
- Reset (rst_n low, async): every output, register and counter is 0; FSM in COLLECT; in_ready is 0 until the first cycle after reset release.
- Chunk assembly: the current operand register shifts left by IN_W and in_data enters the LSBs, so the first chunk lands in the MSBs. CHUNKS = DATA_W/IN_W chunks per operand; operand 0 is filled first.
- FSM COLLECT:
  - in_ready = 1 when outstanding < MAX_OUT, otherwise 0.
  - A chunk is accepted on in_valid && in_ready.
  - Acceptance of the final chunk of operand NUM_OPS-1 moves the FSM to ISSUE. dut_valid rises the next cycle (latency 1).
- FSM ISSUE:
  - dut_valid = 1, in_ready = 0, and dut_ops are held stable until dut_ready.
  - On dut_valid && dut_ready: issue_cnt++ and outstanding++, then return to COLLECT next cycle. Chunk counters restart at operand 0, chunk 0.
- Results: on res_valid with (outstanding > 0 or an issue in the same cycle):
  - signature <= (signature<<1) ^ (signature[MSB] ? POLY : 0) ^ res_data
  - res_cnt++ and outstanding--.
- Spurious result: res_valid with outstanding == 0 and no issue that cycle sets err_spurious. The result is not folded and not counted.
- Simultaneous issue and result: outstanding is unchanged, both counters increment, and the result is folded.
- Watchdog:
  - Counts cycles while outstanding > 0 and no res_valid; resets to 0 on any res_valid or when outstanding == 0.
  - Reaching TIMEOUT sets err_timeout (sticky). Operation continues.
- Counters: issue_cnt and res_cnt wrap modulo 2^CNT_W. The internal outstanding counter saturates at MAX_OUT by construction.
- clr:
  - Zeroes signature, issue_cnt, res_cnt, the watchdog and both error flags.
  - Does not affect the FSM, partial operands or outstanding.
  - A result in the same cycle as clr is discarded; clr wins.
- Reset mid-operation: a partially assembled operand, pending ISSUE and in-flight count are all dropped; dut_valid falls asynchronously.

Test Plan:
- Defaults: chunks 16'h4000, 16'h0000, 16'h3F80, 16'h0000 on consecutive cycles with dut_ready=1 → dut_valid for 1 cycle, 1 cycle after the 4th chunk, with dut_ops = {32'h3F800000, 32'h40000000}; issue_cnt=1; in_ready low during ISSUE.
- Results 32'h3FB504F3 then 32'h40000000 after two issues → signature 32'h3FB504F3, then 32'h3F6A09E6; res_cnt=2; led[13] = ^signature.
- dut_ready held 0 for 5 cycles in ISSUE → dut_valid and dut_ops stable, in_ready=0, in_valid chunks ignored; ready=1 completes a single issue.
- MAX_OUT=2, three full operations, no results → in_ready=0 after the second issue; one result re-opens in_ready the next cycle. Issue and result in the same cycle keep outstanding constant.
- res_valid with nothing outstanding → err_spurious=1 and signature unchanged. TIMEOUT=16 with one op outstanding and no result → err_timeout set at cycle 16. clr → both flags, counters and signature zero.
- rst_n pulsed low after 3 of 4 chunks → all outputs 0 immediately; 4 fresh chunks are needed for the next issue.
